// File: rtl/ctrl_defs.sv
// Shared opcode encodings, micro-step indices and control-word layout for the
// control unit and the assembler-side test data.
package ctrl_defs;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] STEP_T0 = 3'd0;
  localparam logic [2:0] STEP_T1 = 3'd1;
  localparam logic [2:0] STEP_T2 = 3'd2;
  localparam logic [2:0] STEP_T3 = 3'd3;
  localparam logic [2:0] STEP_T4 = 3'd4;
  localparam logic [2:0] STEP_T5 = 3'd5;

  typedef enum logic [2:0] {
    T0 = STEP_T0,
    T1 = STEP_T1,
    T2 = STEP_T2,
    T3 = STEP_T3,
    T4 = STEP_T4,
    T5 = STEP_T5
  } step_e;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic jmp;
    logic mar_in;
    logic ram_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic sub;
    logic flags_in;
    logic out_in;
  } ctrl_t;

endpackage

// File: rtl/step_counter.sv
// Six-step micro-sequencer with halt latch; clear has priority over halt and advance.
//   state | meaning
//   T0    | fetch: PC to MAR
//   T1    | fetch: RAM to IR
//   T2    | fetch: PC increment
//   T3-T5 | execute micro-ops (T4 is also the frozen step while halted)
module step_counter
  import ctrl_defs::*;
(
  input  logic  clock,
  input  logic  clear,
  input  logic  halt_req_i,
  output step_e step_o,
  output logic  halted_o
);

  step_e step_q, step_d;
  logic  halted_q, halted_d;

  always_ff @(posedge clock) begin
    if (clear) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      unique case (step_q)
        T0:      step_d = T1;
        T1:      step_d = T2;
        T2:      step_d = T3;
        T3:      step_d = T4;
        T4:      step_d = T5;
        T5:      step_d = T0;
        default: step_d = T0;
      endcase
      // Halt is requested only in T3, so the counter parks on T4.
      if (halt_req_i) halted_d = 1'b1;
    end
  end

  assign step_o   = step_q;
  assign halted_o = halted_q;

endmodule

// File: rtl/control_unit.sv
// Microcoded control unit: fixed 3-step fetch, opcode-dependent execute steps,
// all control lines decoded combinationally from step, opcode, flags and halt.
module control_unit
  import ctrl_defs::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       jmp,
  output logic       mar_in,
  output logic       ram_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       sub,
  output logic       flags_in,
  output logic       out_in,
  output logic       halted,
  output logic [2:0] t_state
);

  step_e step;
  logic  halt_req;
  ctrl_t ctl;

  step_counter u_step (
    .clock      (clock),
    .clear      (clear),
    .halt_req_i (halt_req),
    .step_o     (step),
    .halted_o   (halted)
  );

  assign halt_req = !halted && (step == T3) && (opcode == OP_HLT);

  always_comb begin
    ctl = '0;
    if (!halted) begin
      unique case (step)
        T0: begin ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; end
        T1: begin ctl.ram_out = 1'b1; ctl.ir_in = 1'b1; end
        T2: ctl.pc_inc = 1'b1;
        T3: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ctl.ir_out = 1'b1; ctl.mar_in = 1'b1; end
            OP_LDI: begin ctl.ir_out = 1'b1; ctl.a_in = 1'b1; end
            OP_JMP: begin ctl.ir_out = 1'b1; ctl.jmp = 1'b1; end
            OP_JC:  begin ctl.ir_out = carry_flag; ctl.jmp = carry_flag; end
            OP_JZ:  begin ctl.ir_out = zero_flag; ctl.jmp = zero_flag; end
            OP_OUT: begin ctl.a_out = 1'b1; ctl.out_in = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          case (opcode)
            OP_LDA:         begin ctl.ram_out = 1'b1; ctl.a_in = 1'b1; end
            OP_ADD, OP_SUB: begin ctl.ram_out = 1'b1; ctl.b_in = 1'b1; end
            OP_STA:         begin ctl.a_out = 1'b1; ctl.ram_in = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctl.alu_out  = 1'b1;
            ctl.a_in     = 1'b1;
            ctl.flags_in = 1'b1;
            ctl.sub      = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_out   = ctl.pc_out;
  assign pc_inc   = ctl.pc_inc;
  assign jmp      = ctl.jmp;
  assign mar_in   = ctl.mar_in;
  assign ram_in   = ctl.ram_in;
  assign ram_out  = ctl.ram_out;
  assign ir_in    = ctl.ir_in;
  assign ir_out   = ctl.ir_out;
  assign a_in     = ctl.a_in;
  assign a_out    = ctl.a_out;
  assign b_in     = ctl.b_in;
  assign alu_out  = ctl.alu_out;
  assign sub      = ctl.sub;
  assign flags_in = ctl.flags_in;
  assign out_in   = ctl.out_in;
  assign t_state  = step;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios with literal
// expectations plus a random run compared every cycle against a step/halt model.
module tb_control_unit;
  import ctrl_defs::*;

  localparam logic [14:0] M_PC_OUT   = 15'h4000;
  localparam logic [14:0] M_PC_INC   = 15'h2000;
  localparam logic [14:0] M_JMP      = 15'h1000;
  localparam logic [14:0] M_MAR_IN   = 15'h0800;
  localparam logic [14:0] M_RAM_IN   = 15'h0400;
  localparam logic [14:0] M_RAM_OUT  = 15'h0200;
  localparam logic [14:0] M_IR_IN    = 15'h0100;
  localparam logic [14:0] M_IR_OUT   = 15'h0080;
  localparam logic [14:0] M_A_IN     = 15'h0040;
  localparam logic [14:0] M_A_OUT    = 15'h0020;
  localparam logic [14:0] M_B_IN     = 15'h0010;
  localparam logic [14:0] M_ALU_OUT  = 15'h0008;
  localparam logic [14:0] M_SUB      = 15'h0004;
  localparam logic [14:0] M_FLAGS_IN = 15'h0002;
  localparam logic [14:0] M_OUT_IN   = 15'h0001;

  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] opcode;
  logic       carry_flag, zero_flag;
  logic pc_out, pc_inc, jmp, mar_in, ram_in, ram_out, ir_in, ir_out;
  logic a_in, a_out, b_in, alu_out, sub, flags_in, out_in, halted;
  logic [2:0] t_state;
  logic [14:0] ctl;

  int  chk_cnt = 0;
  int  pass_cnt = 0;
  bit  cmp_en = 1'b0;
  int  m_t = 0;
  bit  m_h = 1'b0;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .clear(clear), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_out(pc_out), .pc_inc(pc_inc), .jmp(jmp),
    .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out),
    .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in),
    .alu_out(alu_out), .sub(sub), .flags_in(flags_in),
    .out_in(out_in), .halted(halted), .t_state(t_state)
  );

  assign ctl = {pc_out, pc_inc, jmp, mar_in, ram_in, ram_out, ir_in, ir_out,
                a_in, a_out, b_in, alu_out, sub, flags_in, out_in};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Control word required by the instruction table for a given step.
  function automatic logic [14:0] exp_ctl(int t, logic [3:0] op, logic c, logic z, bit h);
    logic [14:0] r;
    r = '0;
    if (h) return r;
    if (t == 0) r = M_PC_OUT | M_MAR_IN;
    else if (t == 1) r = M_RAM_OUT | M_IR_IN;
    else if (t == 2) r = M_PC_INC;
    else if (op == OP_LDA) r = (t == 3) ? (M_IR_OUT | M_MAR_IN) : (t == 4) ? (M_RAM_OUT | M_A_IN) : '0;
    else if (op == OP_ADD || op == OP_SUB)
      r = (t == 3) ? (M_IR_OUT | M_MAR_IN) : (t == 4) ? (M_RAM_OUT | M_B_IN)
        : (M_ALU_OUT | M_A_IN | M_FLAGS_IN | ((op == OP_SUB) ? M_SUB : 15'h0));
    else if (op == OP_STA) r = (t == 3) ? (M_IR_OUT | M_MAR_IN) : (t == 4) ? (M_A_OUT | M_RAM_IN) : '0;
    else if (t == 3) begin
      if (op == OP_LDI) r = M_IR_OUT | M_A_IN;
      else if (op == OP_JMP || (op == OP_JC && c) || (op == OP_JZ && z)) r = M_IR_OUT | M_JMP;
      else if (op == OP_OUT) r = M_A_OUT | M_OUT_IN;
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (clear) begin
      m_t = 0;
      m_h = 1'b0;
    end else if (!m_h) begin
      if (m_t == 3 && opcode == OP_HLT) m_h = 1'b1;
      m_t = (m_t + 1) % 6;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      int drivers;
      check("m_t_state", {29'b0, t_state}, m_t);
      check("m_halted", {31'b0, halted}, {31'b0, m_h});
      check("m_ctl", {17'b0, ctl}, {17'b0, exp_ctl(m_t, opcode, carry_flag, zero_flag, m_h)});
      drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
      chk_cnt++;
      if (drivers <= 1) pass_cnt++;
      else $display("FAIL bus_drivers: got %0d drivers expected at most 1", drivers);
      chk_cnt++;
      if (!(pc_inc && jmp)) pass_cnt++;
      else $display("FAIL inc_jmp: got pc_inc=%b jmp=%b expected not both", pc_inc, jmp);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  logic [14:0] nop_tab [6];
  logic [14:0] sub_tab [6];

  initial begin
    nop_tab = '{M_PC_OUT | M_MAR_IN, M_RAM_OUT | M_IR_IN, M_PC_INC, 15'h0, 15'h0, 15'h0};
    sub_tab = '{M_PC_OUT | M_MAR_IN, M_RAM_OUT | M_IR_IN, M_PC_INC, M_IR_OUT | M_MAR_IN,
                M_RAM_OUT | M_B_IN, M_ALU_OUT | M_A_IN | M_FLAGS_IN | M_SUB};
    clear = 1'b1; opcode = OP_NOP; carry_flag = 1'b0; zero_flag = 1'b0;
    cyc();
    cyc();
    clear = 1'b0;
    cmp_en = 1'b1;

    // NOP free run from reset, including wrap back to T0
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      check("nop_t", {29'b0, t_state}, i % 6);
      check("nop_ctl", {17'b0, ctl}, {17'b0, nop_tab[i % 6]});
      if (i == 0) check("rst_halted", {31'b0, halted}, 32'd0);
      cyc();
    end

    do_reset();
    opcode = OP_SUB;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("sub_ctl", {17'b0, ctl}, {17'b0, sub_tab[i]});
      check("sub_bit", {31'b0, sub}, (i == 5) ? 32'd1 : 32'd0);
      cyc();
    end

    do_reset();
    opcode = OP_JC; carry_flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 3) check("jc_nc_t3", {17'b0, ctl}, 32'd0);
      cyc();
    end
    do_reset();
    carry_flag = 1'b1;
    cyc(); cyc(); cyc();
    @(negedge clock);
    check("jc_c_t3", {17'b0, ctl}, {17'b0, M_IR_OUT | M_JMP});
    cyc();
    carry_flag = 1'b0;
    @(negedge clock);
    check("jc_t4", {17'b0, ctl}, 32'd0);
    check("jc_t4_step", {29'b0, t_state}, 32'd4);
    cyc();
    carry_flag = 1'b1;
    @(negedge clock);
    check("jc_t5", {17'b0, ctl}, 32'd0);
    cyc();

    do_reset();
    opcode = OP_HLT;
    cyc(); cyc(); cyc();
    @(negedge clock);
    check("hlt_t3_ctl", {17'b0, ctl}, 32'd0);
    check("hlt_t3_halted", {31'b0, halted}, 32'd0);
    cyc();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("hlt_halted", {31'b0, halted}, 32'd1);
      check("hlt_t", {29'b0, t_state}, 32'd4);
      check("hlt_ctl", {17'b0, ctl}, 32'd0);
      opcode = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom); zero_flag = 1'($urandom);
      cyc();
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    @(negedge clock);
    check("hlt_clr_t", {29'b0, t_state}, 32'd0);
    check("hlt_clr_halted", {31'b0, halted}, 32'd0);
    check("hlt_clr_pc_out", {31'b0, pc_out}, 32'd1);

    // ADD abandoned by clear during T4
    opcode = OP_ADD;
    cyc(); cyc(); cyc(); cyc();
    @(negedge clock);
    check("add_t4_ctl", {17'b0, ctl}, {17'b0, M_RAM_OUT | M_B_IN});
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    opcode = OP_NOP;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("add_clr_t", {29'b0, t_state}, i);
      check("add_clr_a_in", {31'b0, a_in}, 32'd0);
      cyc();
    end

    // Random opcodes, flags and occasional clears, checked by the model process
    for (int i = 0; i < 600; i++) begin
      opcode = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom);
      zero_flag = 1'($urandom);
      clear = ($urandom_range(0, 19) == 0);
      cyc();
    end
    clear = 1'b0;
    @(negedge clock);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- opcode  in  4  instruction register upper nibble
- carry_flag  in  1  registered ALU carry
- zero_flag  in  1  registered ALU zero
- pc_out, pc_inc, jmp  out  1 each  program counter controls
- mar_in, ram_in, ram_out  out  1 each  memory controls
- ir_in, ir_out  out  1 each  instruction register load / operand-to-bus
- a_in, a_out, b_in  out  1 each  register controls
- alu_out, sub, flags_in  out  1 each  ALU controls
- out_in  out  1  output register load
- halted  out  1  processor halted
- t_state  out  3  current micro-step, 0..5

Function
REQ-003 Micro-step counter T0..T5 SHALL advance by one on each rising clock edge and wrap T5->T0; every instruction SHALL take exactly 6 cycles.
REQ-004 All control outputs SHALL be combinational decodes of (t_state, opcode, flags, halted); they are valid for the whole cycle and are consumed by datapath registers at the next rising edge.
REQ-005 Fetch, identical for every opcode:
- T0: pc_out, mar_in
- T1: ram_out, ir_in
- T2: pc_inc
REQ-006 Execute micro-ops, T3/T4/T5; unlisted steps assert nothing:
- 0000 NOP: none
- 0001 LDA: T3 ir_out+mar_in; T4 ram_out+a_in
- 0010 ADD: T3 ir_out+mar_in; T4 ram_out+b_in; T5 alu_out+a_in+flags_in
- 0011 SUB: as ADD, with sub also asserted in T5
- 0100 STA: T3 ir_out+mar_in; T4 a_out+ram_in
- 0101 LDI: T3 ir_out+a_in
- 0110 JMP: T3 ir_out+jmp
- 0111 JC: T3 ir_out+jmp only if carry_flag=1, else none
- 1000 JZ: T3 ir_out+jmp only if zero_flag=1, else none
- 1110 OUT: T3 a_out+out_in
- 1111 HLT: T3 sets halted at the following edge
- 1001..1101: treated as NOP
REQ-007 At most one of pc_out, ram_out, ir_out, a_out, alu_out SHALL be high in any cycle (single bus driver).
REQ-008 pc_inc and jmp SHALL never be high in the same cycle.
REQ-009 JC/JZ SHALL sample the flag value present during T3; flag changes at other steps SHALL have no effect.
REQ-010 While halted=1:
- all control outputs SHALL be 0;
- t_state SHALL freeze at T4;
- only clear exits the halted state.
REQ-011 opcode SHALL be ignored during T0..T2.

Reset
REQ-012 clear=1 at a rising edge SHALL force t_state=0 and halted=0, with priority over halt and step advance, in any step.
REQ-013 After reset, outputs SHALL be the T0 decode: pc_out=1, mar_in=1, all other controls 0, halted=0.
REQ-014 clear asserted mid-instruction SHALL abandon that instruction with no further micro-ops issued.

Structure
REQ-015 Opcode encodings and step indices SHALL be localparams in a shared include, ctrl_defs, reused by the assembler-side test data.
REQ-016 The step counter with halt-freeze and clear SHALL be one sub-module, step_counter; decode SHALL live in control_unit.

Verification
REQ-017 The bench SHALL cover at least the following directed scenarios:
- Reset then free-run with opcode=0000: t_state cycles 0,1,2,3,4,5,0; pc_out+mar_in at T0, ram_out+ir_in at T1, pc_inc at T2, and nothing at T3..T5.
- opcode=0011 (SUB): T3 ir_out+mar_in; T4 ram_out+b_in; T5 alu_out+a_in+flags_in+sub; sub is 0 in every other step.
- opcode=0111 (JC) with carry_flag=0, then with carry_flag=1: T3 asserts nothing, then T3 asserts ir_out+jmp; a carry toggle at T4 has no effect.
- opcode=1111 (HLT): halted=1 from T4 on, all outputs 0 for 20 cycles with t_state=4; a clear pulse gives t_state=0, halted=0, and pc_out=1.
- clear asserted during T4 of ADD: the next cycle is T0 and no a_in pulse is observed.
- Assertion on every cycle of a random opcode/flag run: at most one bus driver high, and pc_inc and jmp never both high.
